bitty_wb_sequencer: RTL

Wishbone-slave controller that queues instructions for the bitty core and issues them one at a time. It drives the core's run, reset and instr inputs, waits for done, and captures d_out into a result register. It raises an interrupt on completion and times out a hung core. It sits between the Wishbone bus and the bitty core inside the user-project wrapper, replacing direct tie-offs of run/instr.

---
 rtl/bitty_seq_pkg.sv | 32 +++
 rtl/bitty_instr_fifo.sv | 55 +++++
 rtl/bitty_wb_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bitty_seq_pkg.sv
// Shared definitions for the bitty instruction sequencer: register indices,
// CTRL/STATUS bit positions and the sequencer state encoding.
package bitty_seq_pkg;

    // Register indices decoded from wbs_adr_i[4:2]
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_INSTR   = 3'd1;
    localparam logic [2:0] REG_RESULT  = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_DONECNT = 3'd4;

    // CTRL bits
    localparam int CTRL_EN       = 0;
    localparam int CTRL_SOFT_RST = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // STATUS bits ([3:0] hold the FIFO count)
    localparam int ST_EMPTY   = 4;
    localparam int ST_FULL    = 5;
    localparam int ST_BUSY    = 6;
    localparam int ST_DONE    = 8;
    localparam int ST_TIMEOUT = 9;
    localparam int ST_OVF     = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } seq_state_t;

endpackage

// File: rtl/bitty_instr_fifo.sv
// Synchronous instruction FIFO. A push while full is dropped; flush empties
// the queue and takes priority over push/pop in the same cycle.
module bitty_instr_fifo #(
    parameter  int BITS  = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    input  logic            pop,
    input  logic            flush,
    output logic [BITS-1:0] head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bitty_wb_sequencer.sv
// Wishbone-slave sequencer for the bitty core: queues instructions, issues
// them one at a time, captures results, raises an irq and times out a hung
// core. Optional macro BITTY_SEQ_PERF_EN adds a saturating busy-cycle
// counter at STATUS[31:16].
module bitty_wb_sequencer
    import bitty_seq_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            core_run_o,
    output logic            core_reset_o,
    output logic [BITS-1:0] core_instr_o,
    input  logic            core_done_i,
    input  logic [BITS-1:0] core_dout_i,
    output logic            irq_o
);

    localparam int         CW  = $clog2(DEPTH + 1);
    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    seq_state_t      state;
    logic [7:0]      wait_cnt;
    logic            rst_pulse;
    logic            enable, irq_en;
    logic            done_sticky, to_sticky, ovf_sticky;
    logic [BITS-1:0] result;
    logic [15:0]     done_cnt;
    logic [31:0]     rdata;

    logic [BITS-1:0] fifo_head;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Bus decode: a transfer is accepted only while ack is low
    logic       valid, acc, wr_acc, rd_acc;
    logic [2:0] idx;
    logic       ctrl_wr, instr_wr, status_wr, soft_rst;
    logic       capture_evt, timeout_evt;
    logic       unused_bits;

    assign valid     = wbs_cyc_i & wbs_stb_i;
    assign acc       = valid & ~wbs_ack_o;
    assign wr_acc    = acc & wbs_we_i & (|wbs_sel_i);
    assign rd_acc    = acc & ~wbs_we_i;
    assign idx       = wbs_adr_i[4:2];
    assign ctrl_wr   = wr_acc && (idx == REG_CTRL);
    assign instr_wr  = wr_acc && (idx == REG_INSTR);
    assign status_wr = wr_acc && (idx == REG_STATUS);
    assign soft_rst  = ctrl_wr & wbs_dat_i[CTRL_SOFT_RST];

    // A soft reset aborts whatever the FSM would have done this cycle
    assign capture_evt = (state == S_CAPTURE) & ~soft_rst;
    assign timeout_evt = (state == S_WAIT) & ~core_done_i & (wait_cnt == TO8) & ~soft_rst;

    assign core_reset_o = wb_rst_i | rst_pulse;
    assign unused_bits  = &{1'b0, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i};

    bitty_instr_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (instr_wr),
        .push_data (wbs_dat_i[BITS-1:0]),
        .pop       (state == S_ISSUE),
        .flush     (soft_rst),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef BITTY_SEQ_PERF_EN
    logic [15:0] busy_cyc;

    // Saturating count of cycles spent outside IDLE
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || soft_rst)                     busy_cyc <= '0;
        else if (state != S_IDLE && busy_cyc != '1)   busy_cyc <= busy_cyc + 16'd1;
    end
`endif

    // Read mux; unmapped addresses and bits read as zero
    always_comb begin
        rdata = '0;
        case (idx)
            REG_CTRL: begin
                rdata[CTRL_EN]     = enable;
                rdata[CTRL_IRQ_EN] = irq_en;
            end
            REG_RESULT:  rdata = 32'(result);
            REG_STATUS: begin
                rdata[3:0]        = 4'(fifo_count);
                rdata[ST_EMPTY]   = fifo_empty;
                rdata[ST_FULL]    = fifo_full;
                rdata[ST_BUSY]    = (state != S_IDLE);
                rdata[ST_DONE]    = done_sticky;
                rdata[ST_TIMEOUT] = to_sticky;
                rdata[ST_OVF]     = ovf_sticky;
`ifdef BITTY_SEQ_PERF_EN
                rdata[31:16]      = busy_cyc;
`endif
            end
            REG_DONECNT: rdata = {16'h0, done_cnt};
            default:     rdata = '0;
        endcase
    end

    // Issue/wait/capture sequencing with registered core-side outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            core_run_o   <= 1'b0;
            core_instr_o <= '0;
            rst_pulse    <= 1'b0;
            result       <= '0;
            done_cnt     <= '0;
        end else begin
            rst_pulse <= 1'b0;
            if (soft_rst) begin
                state      <= S_IDLE;
                core_run_o <= 1'b0;
                rst_pulse  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (enable && !fifo_empty) state <= S_ISSUE;
                    S_ISSUE: begin
                        core_instr_o <= fifo_head;
                        core_run_o   <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= S_WAIT;
                    end
                    S_WAIT: begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (core_done_i) begin
                            state <= S_CAPTURE;
                        end else if (wait_cnt == TO8) begin
                            rst_pulse  <= 1'b1;
                            core_run_o <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                    S_CAPTURE: begin
                        result     <= core_dout_i;
                        done_cnt   <= done_cnt + 16'd1;
                        core_run_o <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Bus handshake, control register, sticky flags and interrupt
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            done_sticky <= 1'b0;
            to_sticky   <= 1'b0;
            ovf_sticky  <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= rd_acc ? rdata : 32'h0;
            if (ctrl_wr) begin
                enable <= wbs_dat_i[CTRL_EN];
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            // A new event beats a same-cycle clear
            done_sticky <= capture_evt | (done_sticky & ~(status_wr & wbs_dat_i[ST_DONE]));
            to_sticky   <= timeout_evt | (to_sticky & ~(status_wr & wbs_dat_i[ST_TIMEOUT]));
            ovf_sticky  <= (instr_wr & fifo_full) | (ovf_sticky & ~(status_wr & wbs_dat_i[ST_OVF]));
            irq_o       <= irq_en & (done_sticky | to_sticky);
        end
    end

endmodule
